// File: rtl/exp_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exp_stream_ctrl
// Description : Stream controller for the e^x accelerator. It buffers U0.16
//               samples in a small FIFO and issues them one at a time to the
//               engine. Each U2.16 result is presented on a valid/ready
//               stream, and a saturating running sum of the results is kept.
//               Optional macro EXP_TIMEOUT_EN adds a watchdog on the engine
//               wait with a sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_stream_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    output logic             exp_start,
    output logic [15:0]      exp_x,
    input  logic             exp_done,
    input  logic [1:0]       exp_int,
    input  logic [15:0]      exp_frac,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [17:0]      res_data,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_sum,
    output logic             acc_ovf,
    output logic             busy,
    output logic             err
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_timeout;
    logic [15:0]          r_exp_x;
    logic [17:0]          r_res_data;
    logic [ACC_W-1:0]     r_acc_sum;
    logic                 r_acc_ovf;
    logic [ACC_W:0]       w_acc_add;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_capture = (r_state == S_WAIT) && exp_done;
    assign w_acc_add = {1'b0, r_acc_sum} + (ACC_W + 1)'({exp_int, exp_frac});

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_x;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: a timeout is treated like a completion with a poison result
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_capture || w_timeout) w_state_nxt = S_OUT;
            S_OUT:   if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand and result registers; both hold until their next load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp_x    <= '0;
            r_res_data <= '0;
        end else begin
            if (w_pop) r_exp_x <= r_mem[r_rd_ptr];
            if (w_capture)      r_res_data <= {exp_int, exp_frac};
            else if (w_timeout) r_res_data <= 18'h3FFFF;
        end
    end

    // Saturating accumulator; a clear beats a same-cycle capture
    always_ff @(posedge clk) begin
        if (!rst_n || acc_clr) begin
            r_acc_sum <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_capture) begin
            if (w_acc_add[ACC_W]) begin
                r_acc_sum <= '1;
                r_acc_ovf <= 1'b1;
            end else begin
                r_acc_sum <= w_acc_add[ACC_W-1:0];
            end
        end
    end

`ifdef EXP_TIMEOUT_EN
    localparam int               c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_err;

    // Expiry fires on the edge that ends the TIMEOUT-th WAIT cycle unless done wins
    assign w_timeout = (r_state == S_WAIT) && !exp_done && (r_tmo_cnt == c_tmo_last);

    // WAIT-cycle counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                   r_tmo_cnt <= '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;

    // TIMEOUT only has meaning when the watchdog is built in
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    assign in_ready  = !w_full;
    assign exp_start = (r_state == S_ISSUE);
    assign exp_x     = r_exp_x;
    assign res_valid = (r_state == S_OUT);
    assign res_data  = r_res_data;
    assign acc_sum   = r_acc_sum;
    assign acc_ovf   = r_acc_ovf;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire
